// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch sequencer.
// Drives the PC update strobe, the memory request and the fetched-instruction handshake.
module instr_fetch #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_fetch_en,
  input  logic [31:0] i_current_pc,
  output logic        o_pc_write,
  output logic [31:0] o_next_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic        o_fetch_fault,
  output logic [1:0]  o_fault_cause
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_UPDATE,
    S_HOLD,
    S_FAULT
  } state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);
  localparam logic [1:0] LP_C_TIMEOUT = 2'b01;
  localparam logic [1:0] LP_C_ALIGN   = 2'b10;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_pend;
  logic        r_squash;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [1:0]  r_cause;

  logic        w_in_req;
  logic        w_in_upd;
  logic        w_misalign;
  logic        w_timeout;
  logic [31:0] w_seq_pc;
  logic [31:0] w_upd_pc;
  state_t      w_resume;

  assign w_in_req   = (r_state == S_REQ);
  assign w_in_upd   = (r_state == S_UPDATE);
  assign w_misalign = |i_current_pc[1:0];
  // A zero limit never matches because the check is gated on LP_MAX.
  assign w_timeout  = (LP_MAX != 8'd0)
                   && (r_wait_cnt == LP_MAX)
                   && !i_mem_ready;
  assign w_seq_pc   = r_instr_pc + 32'd4;
  assign w_resume   = i_fetch_en ? S_REQ : S_IDLE;

  // Late redirect beats a parked one, which beats the sequential PC.
  always_comb begin
    w_upd_pc = w_seq_pc;
    if (i_redirect_valid)
      w_upd_pc = i_redirect_target;
    else if (r_squash)
      w_upd_pc = r_pend;
  end

  // Address tracks the live PC so a request never names a stale address.
  assign o_mem_req     = w_in_req && !w_misalign;
  assign o_mem_addr    = w_in_req ? i_current_pc : 32'd0;
  assign o_pc_write    = w_in_upd;
  assign o_next_pc     = w_in_upd ? w_upd_pc : 32'd0;
  assign o_instr_valid = (r_state == S_HOLD);
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_fetch_fault = (r_state == S_FAULT);
  assign o_fault_cause = r_cause;

  // Fetch sequencer: state, wait counter, redirect parking and capture.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 8'd0;
      r_pend     <= 32'd0;
      r_squash   <= 1'b0;
      r_instr    <= 32'd0;
      r_instr_pc <= 32'd0;
      r_cause    <= 2'b00;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_redirect_valid) begin
            r_pend   <= i_redirect_target;
            r_squash <= 1'b1;
            r_state  <= S_UPDATE;
          end else if (i_fetch_en) begin
            r_wait_cnt <= 8'd0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_misalign) begin
            r_cause <= LP_C_ALIGN;
            r_state <= S_FAULT;
          end else if (i_mem_ready) begin
            r_instr    <= i_mem_rdata;
            r_instr_pc <= i_current_pc;
            r_state    <= S_UPDATE;
            if (i_redirect_valid) begin
              r_pend   <= i_redirect_target;
              r_squash <= 1'b1;
            end
          end else if (w_timeout) begin
            r_cause <= LP_C_TIMEOUT;
            r_state <= S_FAULT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (i_redirect_valid) begin
              r_pend   <= i_redirect_target;
              r_squash <= 1'b1;
            end
          end
        end
        S_UPDATE: begin
          if (r_squash) begin
            r_squash   <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_state    <= w_resume;
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_redirect_valid) begin
            r_pend   <= i_redirect_target;
            r_squash <= 1'b1;
            r_state  <= S_UPDATE;
          end else if (i_instr_ready) begin
            r_wait_cnt <= 8'd0;
            r_state    <= w_resume;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a transaction-level
// expectation queue and a per-cycle protocol checker.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        instr_ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] tgt = 32'd0;

  logic        o_pc_write;
  logic [31:0] o_next_pc;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_fetch_fault;
  logic [1:0]  o_fault_cause;

  always #5 clk = ~clk;

  instr_fetch #(.MAX_WAIT(3)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_fetch_en       (fetch_en),
    .i_current_pc     (pc),
    .o_pc_write       (o_pc_write),
    .o_next_pc        (o_next_pc),
    .o_mem_req        (o_mem_req),
    .o_mem_addr       (o_mem_addr),
    .i_mem_ready      (mem_ready),
    .i_mem_rdata      (rdata),
    .o_instr_valid    (o_instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instr          (o_instr),
    .o_instr_pc       (o_instr_pc),
    .i_redirect_valid (redir),
    .i_redirect_target(tgt),
    .o_fetch_fault    (o_fetch_fault),
    .o_fault_cause    (o_fault_cause)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] q_np[$];
  logic [31:0] q_ins[$];
  logic [31:0] q_ipc[$];

  logic        s_req, s_pw, s_valid, s_fault;
  logic [31:0] s_addr, s_np, s_instr, s_ipc;
  logic [1:0]  s_cause;

  logic        prev_v = 1'b0;
  logic [31:0] prev_i = 32'd0;
  logic [31:0] prev_p = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  // One clock: snapshot outputs mid-cycle, then let the PC register follow.
  task automatic tick();
    @(negedge clk);
    s_req   = o_mem_req;
    s_addr  = o_mem_addr;
    s_pw    = o_pc_write;
    s_np    = o_next_pc;
    s_valid = o_instr_valid;
    s_instr = o_instr;
    s_ipc   = o_instr_pc;
    s_fault = o_fetch_fault;
    s_cause = o_fault_cause;
    @(posedge clk);
    #1;
    if (s_pw) pc = s_np;
  endtask

  task automatic drain(input string nm);
    chk({nm, "_np_left"}, 32'(q_np.size()), 32'd0);
    chk({nm, "_ins_left"}, 32'(q_ins.size()), 32'd0);
    q_np.delete();
    q_ins.delete();
    q_ipc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_en = 1'b0;
    mem_ready = 1'b0;
    rdata = 32'd0;
    instr_ready = 1'b0;
    redir = 1'b0;
    tgt = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Complete one plain fetch from REQ: lat idle waits, respond, accept.
  task automatic fetch_one(input int lat, input logic next_en);
    mem_ready = 1'b0;
    repeat (lat) tick();
    mem_ready = 1'b1;
    rdata = memf(pc);
    q_np.push_back(pc + 32'd4);
    q_ins.push_back(memf(pc));
    q_ipc.push_back(pc);
    tick();
    mem_ready = 1'b0;
    rdata = 32'd0;
    tick();
    instr_ready = 1'b0;
    tick();
    instr_ready = 1'b1;
    fetch_en = next_en;
    tick();
    instr_ready = 1'b0;
  endtask

  // Protocol checker against the expectation queues, every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_req) begin
        chk("req_addr", o_mem_addr, pc);
        chk("req_align", {30'd0, o_mem_addr[1:0]}, 32'd0);
      end
      if (o_pc_write) begin
        if (q_np.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_pc_write: got next_pc %h want none",
                   o_next_pc);
        end else begin
          chk("next_pc", o_next_pc, q_np.pop_front());
        end
      end
      if (o_instr_valid && !prev_v) begin
        if (q_ins.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_instr: got instr %h want none", o_instr);
        end else begin
          chk("instr", o_instr, q_ins.pop_front());
          chk("instr_pc", o_instr_pc, q_ipc.pop_front());
        end
      end
      if (o_instr_valid && prev_v) begin
        chk("hold_instr", o_instr, prev_i);
        chk("hold_pc", o_instr_pc, prev_p);
      end
      chkb("pw_and_valid", o_pc_write & o_instr_valid, 1'b0);
      if (o_fetch_fault)
        chk("fault_quiet",
            {29'd0, o_mem_req, o_instr_valid, o_pc_write}, 32'd0);
    end
    prev_v = o_instr_valid;
    prev_i = o_instr;
    prev_p = o_instr_pc;
  end

  initial begin
    // Reset state and first fetch from 0x0.
    do_reset();
    chk("rst_outs",
        {26'd0, s_req, s_pw, s_valid, s_fault, s_cause}, 32'd0);
    chk("rst_np", s_np, 32'd0);
    chk("rst_addr", s_addr, 32'd0);
    chk("rst_instr", s_instr, 32'd0);
    chk("rst_ipc", s_ipc, 32'd0);
    pc = 32'd0;
    fetch_en = 1'b1;
    tick();
    chkb("first_req_late", s_req, 1'b0);
    tick();
    chkb("req_up", s_req, 1'b1);
    chk("req_addr0", s_addr, 32'h0);
    mem_ready = 1'b1;
    rdata = 32'h0000_0013;
    q_np.push_back(32'h4);
    q_ins.push_back(32'h13);
    q_ipc.push_back(32'h0);
    tick();
    mem_ready = 1'b0;
    tick();
    chkb("upd_pw", s_pw, 1'b1);
    chk("upd_np", s_np, 32'h4);
    tick();
    chkb("hold_v", s_valid, 1'b1);
    chk("hold_i", s_instr, 32'h13);
    chk("hold_p", s_ipc, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    chk("after_accept_addr", s_addr, 32'h4);
    fetch_one(1, 1'b1);
    fetch_one(0, 1'b0);
    tick();
    drain("basic");

    // Wrap of the sequential PC at the top of the address space.
    pc = 32'hFFFF_FFFC;
    fetch_en = 1'b1;
    tick();
    fetch_one(2, 1'b1);
    chk("wrap_pc", pc, 32'h0);
    fetch_one(0, 1'b0);
    tick();
    drain("wrap");

    // Redirect during the second REQ wait; response on the last legal wait.
    do_reset();
    pc = 32'h20;
    fetch_en = 1'b1;
    tick();
    tick();
    redir = 1'b1;
    tgt = 32'h100;
    q_np.push_back(32'h100);
    tick();
    redir = 1'b0;
    tick();
    chkb("req_kept", s_req, 1'b1);
    chk("addr_kept", s_addr, 32'h20);
    mem_ready = 1'b1;
    rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    tick();
    chkb("redir_pw", s_pw, 1'b1);
    chk("redir_np", s_np, 32'h100);
    tick();
    chk("redir_addr", s_addr, 32'h100);
    chkb("no_fault_edge", s_fault, 1'b0);
    fetch_one(0, 1'b0);
    tick();
    drain("redir_req");

    // Accept and redirect in the same HOLD cycle.
    do_reset();
    pc = 32'h8;
    fetch_en = 1'b1;
    tick();
    mem_ready = 1'b1;
    rdata = memf(32'h8);
    q_np.push_back(32'hC);
    q_ins.push_back(memf(32'h8));
    q_ipc.push_back(32'h8);
    tick();
    mem_ready = 1'b0;
    tick();
    instr_ready = 1'b1;
    redir = 1'b1;
    tgt = 32'h40;
    q_np.push_back(32'h40);
    tick();
    chkb("hold_seen", s_valid, 1'b1);
    instr_ready = 1'b0;
    redir = 1'b0;
    tick();
    chkb("hold_redir_v", s_valid, 1'b0);
    chk("hold_redir_np", s_np, 32'h40);
    tick();
    chk("hold_redir_addr", s_addr, 32'h40);
    fetch_one(0, 1'b0);
    tick();
    drain("hold_redir");

    // Redirect from IDLE.
    pc = 32'h0;
    redir = 1'b1;
    tgt = 32'h200;
    fetch_en = 1'b1;
    q_np.push_back(32'h200);
    tick();
    redir = 1'b0;
    tick();
    tick();
    chk("idle_redir_addr", s_addr, 32'h200);
    fetch_one(0, 1'b0);
    tick();
    drain("idle_redir");

    // Timeout with MAX_WAIT=3.
    do_reset();
    pc = 32'h10;
    fetch_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chkb("to_req", s_req, 1'b1);
    end
    tick();
    chkb("to_fault", s_fault, 1'b1);
    chk("to_cause", {30'd0, s_cause}, 32'd1);
    chkb("to_noreq", s_req, 1'b0);
    redir = 1'b1;
    tgt = 32'h80;
    repeat (3) tick();
    redir = 1'b0;
    chkb("to_sticky", s_fault, 1'b1);
    chk("to_cause2", {30'd0, s_cause}, 32'd1);
    do_reset();
    chkb("to_cleared", s_fault, 1'b0);
    chk("to_cause_clr", {30'd0, s_cause}, 32'd0);
    drain("timeout");

    // Misaligned PC.
    pc = 32'h2;
    fetch_en = 1'b1;
    tick();
    tick();
    chkb("mis_noreq", s_req, 1'b0);
    tick();
    chkb("mis_fault", s_fault, 1'b1);
    chk("mis_cause", {30'd0, s_cause}, 32'd2);
    chkb("mis_noreq2", s_req, 1'b0);
    drain("misalign");

    // Reset in the middle of a REQ wait with a response during reset.
    do_reset();
    pc = 32'h30;
    fetch_en = 1'b1;
    tick();
    tick();
    chkb("mid_req", s_req, 1'b1);
    rst = 1'b1;
    mem_ready = 1'b1;
    rdata = 32'h1234_5678;
    tick();
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    fetch_en = 1'b0;
    tick();
    chkb("rr_pw", s_pw, 1'b0);
    chkb("rr_v", s_valid, 1'b0);
    chkb("rr_req", s_req, 1'b0);
    tick();
    chkb("rr_idle", s_req | s_pw | s_valid, 1'b0);
    drain("reset_req");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter MAX_WAIT, default 255, SHALL set the maximum number of REQ cycles without mem_ready before a timeout fault; 0 disables the timeout; range 0..255.
REQ-002 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 fetch_en  input  1  SHALL permit new fetches.
REQ-005 current_pc  input  32  SHALL carry the program counter value.
REQ-006 pc_write  output  1  SHALL be the PC update strobe.
REQ-007 next_pc  output  32  SHALL carry the value loaded into the PC when pc_write=1.
REQ-008 mem_req  output  1  SHALL be the instruction memory request.
REQ-009 mem_addr  output  32  SHALL carry the request address.
REQ-010 mem_ready  input  1  SHALL be the memory response strobe.
REQ-011 mem_rdata  input  32  SHALL carry the response data.
REQ-012 instr_valid  output  1  SHALL mark a fetched instruction as available.
REQ-013 instr_ready  input  1  SHALL mark downstream acceptance.
REQ-014 instr  output  32  SHALL carry the fetched instruction word.
REQ-015 instr_pc  output  32  SHALL carry the fetched instruction's address.
REQ-016 redirect_valid  input  1  SHALL request a control-flow redirect.
REQ-017 redirect_target  input  32  SHALL carry the redirect address.
REQ-018 fetch_fault  output  1  SHALL be a sticky fault flag.
REQ-019 fault_cause  output  2  SHALL encode the fault: 01 timeout, 10 misaligned, 00 none.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, UPDATE, HOLD and FAULT.
REQ-021 IDLE: redirect_valid -> UPDATE with squash; else fetch_en -> REQ; else stay in IDLE.
REQ-022 REQ: mem_addr SHALL equal current_pc, and mem_req SHALL be 1 only while current_pc[1:0]==00.
REQ-023 REQ with current_pc[1:0]!=00 SHALL go to FAULT next cycle with cause 10 and SHALL never assert mem_req.
REQ-024 REQ with mem_ready=1 SHALL capture instr=mem_rdata and instr_pc=mem_addr, then go to UPDATE.
REQ-025 The wait counter SHALL clear on REQ entry and increment per REQ cycle with mem_ready=0; when it equals MAX_WAIT (MAX_WAIT!=0) and mem_ready=0 -> FAULT, cause 01.
REQ-026 redirect_valid during REQ SHALL store redirect_target in a pending register and set squash (last redirect wins); mem_req SHALL stay asserted and mem_addr stable until mem_ready.
REQ-027 UPDATE lasts exactly 1 cycle with pc_write=1.
REQ-028 In UPDATE, next_pc SHALL be, by priority: redirect_valid this cycle -> redirect_target; else pending target if squash; else instr_pc+4 (modulo 2^32, wrap 0xFFFFFFFC -> 0x00000000).
REQ-029 UPDATE exit: squash set -> clear squash, REQ if fetch_en else IDLE, captured instruction discarded; else HOLD.
REQ-030 HOLD: instr_valid=1; instr and instr_pc SHALL be held stable.
REQ-031 HOLD with instr_ready=1 and redirect_valid=0 -> REQ if fetch_en else IDLE.
REQ-032 HOLD with redirect_valid=1 -> UPDATE with squash; instr_valid SHALL drop next cycle; simultaneous instr_ready counts as accepted.
REQ-033 pc_write SHALL be 0 in every state other than UPDATE; at most one pc_write pulse per fetch or redirect.
REQ-034 FAULT: mem_req=0, instr_valid=0, pc_write=0; redirect_valid and fetch_en ignored; exit only by reset.

Reset
REQ-035 reset=1 SHALL on the next edge force IDLE and zero all outputs, counter, pending target and squash.
REQ-036 reset SHALL override every state, including a mid-REQ wait, and any response arriving during reset SHALL be discarded.
REQ-037 The first mem_req after reset SHALL occur no earlier than the second cycle after reset deasserts, with fetch_en=1.

Verification
REQ-038 current_pc=0x0, fetch_en=1, mem_ready 2 cycles later with rdata=0x00000013 -> pc_write one cycle with next_pc=0x4; instr_valid with instr=0x00000013, instr_pc=0x0; after accept, mem_addr=0x4.
REQ-039 redirect_valid (target 0x100) in the 2nd REQ wait cycle -> mem_req held until mem_ready; next_pc=0x100; instr_valid never asserted; next mem_addr=0x100.
REQ-040 HOLD with instr_ready=1 and redirect target 0x40 in the same cycle -> instr accepted, single pc_write with next_pc=0x40.
REQ-041 MAX_WAIT=3, mem_ready held 0 -> FAULT after 4 REQ cycles, fault_cause=01, mem_req=0 thereafter; reset clears the fault.
REQ-042 current_pc=0x2 with fetch_en=1 -> no mem_req; fetch_fault=1, fault_cause=10.
REQ-043 Reset during REQ, then mem_ready=1 -> no pc_write, no instr_valid; IDLE after reset.
